// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM states, address geometry and byte-merge helper for ram_pipelined
package ram_pkg;
  typedef enum logic {INIT, READY} state_t;
  localparam int WORD_OFFSET = 2;
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] new_b, input logic en);
    return en ? new_b : old_b;
  endfunction
endpackage

// File: rtl/ram_lat_pipe.sv
// ram_lat_pipe: valid/error/data delay line of depth LAT; data stages hold between pulses
module ram_lat_pipe #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic         in_error,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_error,
  output logic [W-1:0] out_data
);
  logic [LAT-1:0] v, e;
  logic [W-1:0] d [LAT];
  // shift valid/error every cycle; data stages only load behind a valid so outputs hold
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      v <= '0;
      e <= '0;
      for (int k = 0; k < LAT; k++) d[k] <= '0;
    end else begin
      v[0] <= in_valid;
      e[0] <= in_valid & in_error;
      if (in_valid) d[0] <= in_data;
      for (int k = 1; k < LAT; k++) begin
        v[k] <= v[k-1];
        e[k] <= e[k-1];
        if (v[k-1]) d[k] <= d[k-1];
      end
    end
  assign out_valid = v[LAT-1];
  assign out_error = e[LAT-1];
  assign out_data  = d[LAT-1];
endmodule

// File: rtl/ram_pipelined.sv
// ram_pipelined: i-read + d-read/write unified RAM with zero-fill sweep; RAM_WR_FWD_EN forwards same-cycle d-writes to i-reads
module ram_pipelined
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    ready,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_read_data,
  output logic                    i_error,
  input  logic                    d_req,
  input  logic                    wEn,
  input  logic [DATA_WIDTH/8-1:0] d_byte_en,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_write_data,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_read_data,
  output logic                    d_error
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int AW    = $clog2(DEPTH_WORDS);
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, i_idx, d_idx;
  logic i_err, d_err, i_acc, d_acc, d_wr;
  logic [DATA_WIDTH-1:0] d_merged, i_word, i_data, d_data;
  assign ready = state_q == READY;
  assign i_idx = i_address[AW+WORD_OFFSET-1:WORD_OFFSET];
  assign d_idx = d_address[AW+WORD_OFFSET-1:WORD_OFFSET];
  assign i_err = i_address[WORD_OFFSET-1:0] != '0 || (i_address >> WORD_OFFSET) >= ADDR_WIDTH'(DEPTH_WORDS);
  assign d_err = d_address[WORD_OFFSET-1:0] != '0 || (d_address >> WORD_OFFSET) >= ADDR_WIDTH'(DEPTH_WORDS);
  assign i_acc = ready & i_req;
  assign d_acc = ready & d_req;
  assign d_wr  = d_acc & wEn & ~d_err;
  // byte-merge incoming write data over the currently stored word
  always_comb begin
    d_merged = mem[d_idx];
    for (int b = 0; b < BYTES; b++)
      d_merged[8*b +: 8] = merge_byte(mem[d_idx][8*b +: 8], d_write_data[8*b +: 8], d_byte_en[b]);
  end
`ifdef RAM_WR_FWD_EN
  assign i_word = (d_wr && d_idx == i_idx) ? d_merged : mem[i_idx];
`else
  assign i_word = mem[i_idx];
`endif
  assign i_data = i_err ? '0 : i_word;
  assign d_data = (wEn || d_err) ? '0 : mem[d_idx];
  // sweep ends after the last word is cleared; READY is terminal until reset
  always_comb state_d = (state_q == INIT && idx_q == AW'(DEPTH_WORDS - 1)) ? READY : state_q;
  // state and sweep index registers
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= state_q == INIT ? idx_q + 1'b1 : idx_q;
    end
  // array writes: zero-fill during the sweep, byte-masked d-port writes afterwards
  always_ff @(posedge clock)
    if (state_q == INIT) mem[idx_q] <= '0;
    else if (d_wr) mem[d_idx] <= d_merged;
  ram_lat_pipe #(.W(DATA_WIDTH), .LAT(READ_LATENCY)) u_i_pipe (
    .clock(clock), .reset_n(reset_n), .in_valid(i_acc), .in_error(i_err), .in_data(i_data),
    .out_valid(i_valid), .out_error(i_error), .out_data(i_read_data)
  );
  ram_lat_pipe #(.W(DATA_WIDTH), .LAT(READ_LATENCY)) u_d_pipe (
    .clock(clock), .reset_n(reset_n), .in_valid(d_acc), .in_error(d_err), .in_data(d_data),
    .out_valid(d_valid), .out_error(d_error), .out_data(d_read_data)
  );
endmodule

// File: doc/ram_pipelined.md
Name: ram_pipelined

Overview:
Next-generation unified memory for the EC413 processor: one instruction read port plus one data read/write port over a single word-organised array. Adds parametrised depth and read latency, per-byte write enables, a request/valid handshake, range and alignment checking, and a post-reset zero-fill sweep. Sits between the fetch stage (i-port) and the memory stage (d-port).

Parameters:
DATA_WIDTH, 32, word width in bits (multiple of 8)
ADDR_WIDTH, 16, byte-address width of both ports
DEPTH_WORDS, 1024, number of stored words (power of two, at most 2^(ADDR_WIDTH-2))
READ_LATENCY, 1, cycles from accepted request to valid (legal 1..3)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
ready  out  1  high when requests are accepted (INIT sweep finished)
i_req  in  1  instruction read request
i_address  in  ADDR_WIDTH  instruction byte address
i_valid  out  1  i_read_data valid pulse
i_read_data  out  DATA_WIDTH  instruction word
i_error  out  1  i-request out of range or misaligned (with i_valid)
d_req  in  1  data request
wEn  in  1  1 = write, 0 = read (sampled with d_req)
d_byte_en  in  DATA_WIDTH/8  per-byte write enable
d_address  in  ADDR_WIDTH  data byte address
d_write_data  in  DATA_WIDTH  write data
d_valid  out  1  d-port completion pulse (reads and writes)
d_read_data  out  DATA_WIDTH  read data (0 for writes)
d_error  out  1  d-request out of range or misaligned (with d_valid)

Behaviour:
- Reset (reset_n low, async): ready=0, all valid/error=0, read data=0, pipeline flushed, FSM -> INIT, sweep index=0. Array contents are not reset directly.
- FSM INIT: writes 0 to word[idx] each cycle, idx+1; after word DEPTH_WORDS-1 -> READY (ready=1 the next cycle). INIT lasts exactly DEPTH_WORDS cycles after reset release. Requests during INIT are ignored (no valid ever produced).
- FSM READY: terminal until reset. Reset mid-sweep restarts from idx 0.
- Word index = address[ADDR_WIDTH-1:2]. Error if address[1:0]!=0 or index>=DEPTH_WORDS.
- Accept: request counted on a rising edge where req=1 and ready=1. One request per port per cycle; fully pipelined, no back-pressure.
- Latency: valid/error/data appear exactly READ_LATENCY cycles after the accepting edge, for one cycle. Data outputs hold the last value between pulses.
- Read: returns word as stored at the accepting edge (before any write committed at that edge).
- Write: commits at the accepting edge, only bytes with d_byte_en=1. All-zero byte enable = legal no-op that still acks. Errored writes are dropped. Errored reads return 0.
- Same-cycle i-read and d-write to same word: see Optional Feature.
- Two ports never conflict on writes (only d writes).

Optional Feature:
RAM_WR_FWD_EN: when defined, an i-read accepted in the same cycle as a d-write to the same word returns the byte-merged new data. When undefined, it returns old data. The d-port read of a word written in the previous cycle always sees new data either way.

Decomposition:
- Package ram_pkg: FSM state enum (INIT, READY), BYTES = DATA_WIDTH/8, WORD_OFFSET = 2, function for the byte-merge of write data.
- One natural sub-module: ram_lat_pipe (valid/error/data delay line of depth READ_LATENCY), instantiated once per port.

Test Plan:
- Reset, release, DEPTH_WORDS=16 -> ready rises after exactly 16 cycles; d-read addr 8 -> 0x00000000, d_valid after READ_LATENCY.
- Write 0x11223344 to addr 4 with byte_en 1111, then byte_en 0010 data 0xAABBCCDD -> read addr 4 returns 0x1122CC44.
- Read addr 6 (misaligned) and addr 64 with DEPTH_WORDS=16 -> d_error=1, data 0; write to 64 leaves the array unchanged.
- Same cycle: d-write 0x25 to addr 8, i-read addr 8 (old value 2) -> i_read_data 0x25 with RAM_WR_FWD_EN, 0x2 without.
- READ_LATENCY=3: back-to-back i-reads of addr 0, 4, 8 on consecutive cycles -> three consecutive i_valid pulses in order, starting 3 cycles after the first.
- Assert reset_n low mid-INIT and mid-read -> valids drop immediately, ready=0, full sweep repeats.
